led_counter_ctrl: RTL and testbench

//  Sequencer for the board LED counter datapath on PP3 designs.

---
 rtl/led_counter_ctrl.sv | 77 +++++++
 tb/tb_led_counter_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: command-driven LED counter sequencer with prescaled tick, bounded runs, wrap/done pulses.
module led_counter_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_arg,
    input  logic [PRESCALE_W-1:0] div,
    output logic [WIDTH-1:0]      led,
    output logic                  busy,
    output logic                  wrap,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, APPLY, UP, DOWN} state_t;
    localparam logic [1:0] OP_STOP = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_LOAD = 2'b11;
    state_t                state, next_state;
    logic [1:0]            op_q;
    logic [WIDTH-1:0]      arg_q, steps;
    logic [PRESCALE_W-1:0] presc;
    logic                  accept, running, tick, step, last;
    assign accept  = cmd_valid & cmd_ready;
    assign running = (state == UP) || (state == DOWN);
    assign tick    = running && (presc >= div);
    // an accepted command always preempts a tick on the same edge
    assign step    = tick && !accept;
    assign last    = steps == WIDTH'(1);
    always_comb begin
        next_state = state;
        if (accept)
            next_state = APPLY;
        else if (state == APPLY)
            next_state = (op_q == OP_UP) ? UP : (op_q == OP_DOWN) ? DOWN : IDLE;
        else if (step && last)
            next_state = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            presc     <= '0;
            steps     <= '0;
            op_q      <= OP_STOP;
            arg_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= cmd_op;
                arg_q <= cmd_arg;
            end
            if (state == APPLY && op_q == OP_LOAD)
                led <= arg_q;
            else if (step)
                led <= (state == UP) ? led + WIDTH'(1) : led - WIDTH'(1);
            presc <= (running && !accept && !tick) ? presc + PRESCALE_W'(1) : '0;
            if (state == APPLY)
                steps <= arg_q;
            else if (step && steps != '0)
                steps <= steps - WIDTH'(1);
            wrap      <= step && ((state == UP) ? &led : ~|led);
            done      <= step && last;
            cmd_ready <= next_state != APPLY;
            busy      <= (next_state == UP) || (next_state == DOWN);
        end
    end
endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb_led_counter_ctrl: directed self-checking bench for led_counter_ctrl.
module tb_led_counter_ctrl;
    logic        clk, rst_n, cmd_valid, cmd_ready, busy, wrap, done;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_arg, led;
    logic [19:0] div;
    int checks, errors;

    led_counter_ctrl #(.WIDTH(4), .PRESCALE_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .div(div), .led(led),
        .busy(busy), .wrap(wrap), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // offer one command for a single cycle; returns at the negedge after the accept edge
    task automatic send(input logic [1:0] op, input logic [3:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'h0; div = 20'd0;
        #1;
        chk("rst_led", led, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", cmd_ready, 1);
        repeat (4) @(negedge clk);
        chk("idle_led", led, 0);
        chk("idle_busy", busy, 0);

        // LOAD
        send(2'b11, 4'hA);
        chk("load_apply_ready", cmd_ready, 0);
        chk("load_apply_led", led, 0);
        @(negedge clk);
        chk("load_led", led, 4'hA);
        chk("load_ready", cmd_ready, 1);
        chk("load_busy", busy, 0);

        // free-run up, div=0, wrap at F->0
        send(2'b11, 4'hE);
        @(negedge clk);
        div = 20'd0;
        send(2'b01, 4'h0);
        begin
            logic [3:0] el [6] = '{4'hE, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
            logic       ew [6] = '{0, 0, 0, 1, 0, 0};
            logic       eb [6] = '{0, 1, 1, 1, 1, 1};
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("up_led%0d", i), led, el[i]);
                chk($sformatf("up_wrap%0d", i), wrap, ew[i]);
                chk($sformatf("up_busy%0d", i), busy, eb[i]);
                @(negedge clk);
            end
        end

        // bounded run down, div=3, preempting the free run
        send(2'b11, 4'h1);
        @(negedge clk);
        chk("preload_led", led, 4'h1);
        div = 20'd3;
        send(2'b10, 4'h3);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("dn_led%0d", i), led, i < 5 ? 4'h1 : i < 9 ? 4'h0 : i < 13 ? 4'hF : 4'hE);
            chk($sformatf("dn_wrap%0d", i), wrap, i == 9);
            chk($sformatf("dn_done%0d", i), done, i == 13);
            chk($sformatf("dn_busy%0d", i), busy, i >= 1 && i < 13);
            @(negedge clk);
        end

        // free-run up div=2 from E; STOP lands on the F->0 tick edge
        div = 20'd2;
        send(2'b01, 4'h0);
        repeat (5) @(negedge clk);
        chk("stop_pre_led", led, 4'hF);
        chk("stop_pre_busy", busy, 1);
        send(2'b00, 4'h0);
        chk("stop_edge_led", led, 4'hF);
        chk("stop_edge_wrap", wrap, 0);
        chk("stop_edge_ready", cmd_ready, 0);
        chk("stop_edge_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("stop_hold_led", led, 4'hF);
        chk("stop_hold_busy", busy, 0);

        // async reset mid-run at led=7
        div = 20'd0;
        send(2'b11, 4'h5);
        @(negedge clk);
        send(2'b01, 4'h0);
        repeat (3) @(negedge clk);
        chk("mid_led", led, 4'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", led, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_led", led, 0);
        chk("rel_busy", busy, 0);
        send(2'b11, 4'h3);
        @(negedge clk);
        chk("rel_load_led", led, 4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
